serv_axil_timer: RTL and testbench
==================================

SERV_AXIL_TIMER -- requirements
Module: serv_axil_timer

Interface
REQ-001 SHALL have parameter AW, default 12, giving the AXI-Lite address width.
REQ-002 SHALL have parameter RESET_CMP, default 64'hFFFF_FFFF_FFFF_FFFF, giving the MTIMECMP reset value.
REQ-003 SHALL have ports, one clock, reset asynchronous and active-low:
  clk  in  1  clock
  rst  in  1  asynchronous active-low reset
  i_awaddr  in  AW  write address
  i_awvalid  in  1  write address valid
  o_awready  out  1  write address ready
  i_wdata  in  32  write data
  i_wstrb  in  4  byte strobes
  i_wvalid  in  1  write data valid
  o_wready  out  1  write data ready
  o_bresp  out  2  write response
  o_bvalid  out  1  write response valid
  i_bready  in  1  write response ready
  i_araddr  in  AW  read address
  i_arvalid  in  1  read address valid
  o_arready  out  1  read address ready
  o_rdata  out  32  read data
  o_rresp  out  2  read response
  o_rlast  out  1  constant 1 (single beat)
  o_rvalid  out  1  read data valid
  i_rready  in  1  read data ready
  o_timer_irq  out  1  registered timer interrupt, feeds core i_timer_irq

Function
REQ-004 SHALL decode addr[4:2], ignore addr[1:0]: 0 MTIME_LO, 1 MTIME_HI, 2 CMP_LO, 3 CMP_HI, 4 CTRL; addr[AW-1:5]!=0 or index 5-7 is unmapped.
REQ-005 SHALL implement the write FSM W_IDLE->W_RESP: in W_IDLE assert o_awready and o_wready only when i_awvalid&&i_wvalid, for a single cycle; then W_RESP.
REQ-006 SHALL hold o_bvalid high in W_RESP until i_bready, then return to W_IDLE; bresp 2'b00 mapped, 2'b10 unmapped (no state change).
REQ-007 SHALL apply writes per byte under i_wstrb; wstrb=0 is a legal no-op with OKAY response.
REQ-008 SHALL implement the read FSM R_IDLE->R_DATA: o_arready pulses one cycle on i_arvalid in R_IDLE; o_rvalid asserted next cycle, held with stable o_rdata/o_rresp until i_rready.
REQ-009 SHALL return rdata 0 and rresp 2'b10 for unmapped reads.
REQ-010 SHALL, on reading MTIME_LO, latch MTIME[63:32] into a shadow; MTIME_HI reads return the shadow.
REQ-011 SHALL increment 64-bit MTIME by 1 on each tick while CTRL[0] (enable) is 1, wrapping 2^64-1 -> 0.
REQ-012 SHALL let a same-cycle MTIME write win over increment on the written bytes.
REQ-013 SHALL register o_timer_irq = CTRL[0] && (MTIME >= MTIMECMP), one cycle after the compared values update; unsigned 64-bit compare.
REQ-014 SHALL allow read and write FSMs to run concurrently and independently.

Reset
REQ-015 SHALL on rst low asynchronously clear MTIME, shadow, CTRL, prescale counter, o_timer_irq, o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_bresp, o_rresp, o_rdata; MTIMECMP<=RESET_CMP; FSMs to IDLE.
REQ-016 SHALL abandon any in-flight transaction on reset with no response issued afterwards.

Configuration
REQ-017 SHALL, with SERV_AXIL_TIMER_PRESCALE_EN defined, implement CTRL[15:8] as divisor D: tick every D+1 enabled cycles via an 8-bit counter, cleared when CTRL is written.
REQ-018 SHALL, without the macro, tick every enabled cycle; CTRL[15:8] reads 0, writes ignored.

Structure
REQ-019 SHALL place register indices, RESP_OKAY/RESP_SLVERR and FSM state typedefs in package serv_timer_pkg.
REQ-020 SHALL contain one sub-module serv_axil_timer_regs (register file, counter, comparator); the top holds both AXI FSMs.

Verification
REQ-021 After reset, read CMP_LO -> rdata 32'hFFFF_FFFF, rresp 0, o_timer_irq 0.
REQ-022 Write CMP_LO=10, CMP_HI=0, CTRL=1 -> o_timer_irq rises when MTIME reaches 10, one cycle later.
REQ-023 Write MTIME_LO=FFFF_FFFF, MTIME_HI=FFFF_FFFF, enable -> wraps to 0; irq follows compare.
REQ-024 Write address 0x18 with bready held low 5 cycles -> bvalid held, bresp 2'b10, registers unchanged.
REQ-025 Simultaneous read MTIME_LO and write CMP_LO with wstrb=4'b0001 -> both complete; only byte 0 changes.
REQ-026 With macro, CTRL=0x0301 -> MTIME increments once per 4 cycles; assert rst mid-R_DATA -> rvalid 0 immediately.

Source files
------------

// File: rtl/serv_timer_pkg.sv
// Shared definitions for the AXI-Lite machine timer: register indices,
// AXI response codes, FSM state encodings and a byte-strobe merge helper.
package serv_timer_pkg;

  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [0:0] w_state_t;
  localparam w_state_t W_IDLE = 1'b0;
  localparam w_state_t W_RESP = 1'b1;

  typedef logic [0:0] r_state_t;
  localparam r_state_t R_IDLE = 1'b0;
  localparam r_state_t R_DATA = 1'b1;

  // Replace only the byte lanes selected by strb.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/serv_axil_timer_regs.sv
// Timer register file: 64-bit MTIME counter, MTIMECMP, CTRL, read shadow and
// registered compare interrupt. Optional prescaler under SERV_AXIL_TIMER_PRESCALE_EN.
module serv_axil_timer_regs
  import serv_timer_pkg::*;
#(
  parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  w_idx,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        re,
  input  logic [2:0]  r_idx,
  output logic [31:0] rdata,
  output logic        timer_irq
);

  logic [63:0] mtime_reg;
  logic [63:0] mtime_inc;
  logic [63:0] mtime_next;
  logic [63:0] cmp_reg;
  logic [63:0] cmp_next;
  logic [31:0] shadow_reg;
  logic        ctrl_en_reg;
  logic [31:0] ctrl_rd;
  logic        ctrl_we;
  logic        tick;

  // A CTRL write with no strobes is a no-op and must not disturb the prescaler.
  assign ctrl_we = we && (w_idx == IDX_CTRL) && (wstrb != 4'b0000);

`ifdef SERV_AXIL_TIMER_PRESCALE_EN
  logic [7:0] ctrl_div_reg;
  logic [7:0] presc_cnt_reg;

  assign tick    = ctrl_en_reg && (presc_cnt_reg == ctrl_div_reg);
  assign ctrl_rd = {16'h0000, ctrl_div_reg, 7'h00, ctrl_en_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt_reg <= 8'd0;
      ctrl_div_reg  <= 8'd0;
    end else begin
      if (ctrl_we) begin
        presc_cnt_reg <= 8'd0;
      end else if (ctrl_en_reg) begin
        presc_cnt_reg <= tick ? 8'd0 : presc_cnt_reg + 8'd1;
      end
      if (ctrl_we && wstrb[1]) ctrl_div_reg <= wdata[15:8];
    end
  end
`else
  assign tick    = ctrl_en_reg;
  assign ctrl_rd = {31'h0, ctrl_en_reg};
`endif

  assign mtime_inc = mtime_reg + {63'd0, tick};

  // Written bytes take the bus value; unwritten bytes keep the incremented count.
  always_comb begin
    mtime_next = mtime_inc;
    cmp_next   = cmp_reg;
    if (we) begin
      case (w_idx)
        IDX_MTIME_LO: mtime_next[31:0]  = apply_wstrb(mtime_inc[31:0],  wdata, wstrb);
        IDX_MTIME_HI: mtime_next[63:32] = apply_wstrb(mtime_inc[63:32], wdata, wstrb);
        IDX_CMP_LO:   cmp_next[31:0]    = apply_wstrb(cmp_reg[31:0],    wdata, wstrb);
        IDX_CMP_HI:   cmp_next[63:32]   = apply_wstrb(cmp_reg[63:32],   wdata, wstrb);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_reg   <= 64'd0;
      cmp_reg     <= RESET_CMP;
      shadow_reg  <= 32'd0;
      ctrl_en_reg <= 1'b0;
      timer_irq   <= 1'b0;
    end else begin
      mtime_reg <= mtime_next;
      cmp_reg   <= cmp_next;
      if (ctrl_we && wstrb[0]) ctrl_en_reg <= wdata[0];
      if (re && (r_idx == IDX_MTIME_LO)) shadow_reg <= mtime_reg[63:32];
      timer_irq <= ctrl_en_reg && (mtime_reg >= cmp_reg);
    end
  end

  // MTIME_HI returns the half captured by the last MTIME_LO read for a coherent 64-bit view.
  always_comb begin
    rdata = 32'd0;
    case (r_idx)
      IDX_MTIME_LO: rdata = mtime_reg[31:0];
      IDX_MTIME_HI: rdata = shadow_reg;
      IDX_CMP_LO:   rdata = cmp_reg[31:0];
      IDX_CMP_HI:   rdata = cmp_reg[63:32];
      IDX_CTRL:     rdata = ctrl_rd;
      default:      rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/serv_axil_timer.sv
// AXI-Lite machine timer: independent write and read FSMs around serv_axil_timer_regs.
// Optional prescaler enabled by defining SERV_AXIL_TIMER_PRESCALE_EN.
module serv_axil_timer
  import serv_timer_pkg::*;
#(
  parameter int          AW        = 12,
  parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_awaddr,
  input  logic          i_awvalid,
  output logic          o_awready,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wstrb,
  input  logic          i_wvalid,
  output logic          o_wready,
  output logic [1:0]    o_bresp,
  output logic          o_bvalid,
  input  logic          i_bready,
  input  logic [AW-1:0] i_araddr,
  input  logic          i_arvalid,
  output logic          o_arready,
  output logic [31:0]   o_rdata,
  output logic [1:0]    o_rresp,
  output logic          o_rlast,
  output logic          o_rvalid,
  input  logic          i_rready,
  output logic          o_timer_irq
);

  w_state_t    w_state_reg;
  r_state_t    r_state_reg;
  logic [2:0]  aw_idx;
  logic [2:0]  ar_idx;
  logic        aw_mapped;
  logic        ar_mapped;
  logic        aw_fire;
  logic        ar_fire;
  logic        regs_we;
  logic        regs_re;
  logic [31:0] regs_rdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{i_awaddr[1:0], i_araddr[1:0]};

  assign aw_idx    = i_awaddr[4:2];
  assign ar_idx    = i_araddr[4:2];
  assign aw_mapped = (i_awaddr[AW-1:5] == '0) && (aw_idx <= IDX_CTRL);
  assign ar_mapped = (i_araddr[AW-1:5] == '0) && (ar_idx <= IDX_CTRL);

  // Ready is a registered one-cycle pulse; the handshake lands on the following edge.
  assign aw_fire = (w_state_reg == W_IDLE) && o_awready && i_awvalid && i_wvalid;
  assign ar_fire = (r_state_reg == R_IDLE) && o_arready && i_arvalid;
  assign regs_we = aw_fire && aw_mapped;
  assign regs_re = ar_fire && ar_mapped;
  assign o_rlast = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_reg <= W_IDLE;
      o_awready   <= 1'b0;
      o_wready    <= 1'b0;
      o_bvalid    <= 1'b0;
      o_bresp     <= RESP_OKAY;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (o_awready) begin
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            if (aw_fire) begin
              w_state_reg <= W_RESP;
              o_bvalid    <= 1'b1;
              o_bresp     <= aw_mapped ? RESP_OKAY : RESP_SLVERR;
            end
          end else if (i_awvalid && i_wvalid) begin
            o_awready <= 1'b1;
            o_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (i_bready) begin
            o_bvalid    <= 1'b0;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_reg <= R_IDLE;
      o_arready   <= 1'b0;
      o_rvalid    <= 1'b0;
      o_rdata     <= 32'd0;
      o_rresp     <= RESP_OKAY;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (o_arready) begin
            o_arready <= 1'b0;
            if (ar_fire) begin
              r_state_reg <= R_DATA;
              o_rvalid    <= 1'b1;
              o_rdata     <= ar_mapped ? regs_rdata : 32'd0;
              o_rresp     <= ar_mapped ? RESP_OKAY : RESP_SLVERR;
            end
          end else if (i_arvalid) begin
            o_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (i_rready) begin
            o_rvalid    <= 1'b0;
            r_state_reg <= R_IDLE;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  serv_axil_timer_regs #(
    .RESET_CMP (RESET_CMP)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .we        (regs_we),
    .w_idx     (aw_idx),
    .wdata     (i_wdata),
    .wstrb     (i_wstrb),
    .re        (regs_re),
    .r_idx     (ar_idx),
    .rdata     (regs_rdata),
    .timer_irq (o_timer_irq)
  );

endmodule

// File: tb/tb_serv_axil_timer.sv
// Scoreboard bench for serv_axil_timer: a cycle-level reference model watches
// AXI handshakes and queues expected responses; a monitor pops and compares them.
module tb_serv_axil_timer;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] i_awaddr = '0;
  logic          i_awvalid = 1'b0;
  logic          o_awready;
  logic [31:0]   i_wdata = '0;
  logic [3:0]    i_wstrb = '0;
  logic          i_wvalid = 1'b0;
  logic          o_wready;
  logic [1:0]    o_bresp;
  logic          o_bvalid;
  logic          i_bready = 1'b0;
  logic [AW-1:0] i_araddr = '0;
  logic          i_arvalid = 1'b0;
  logic          o_arready;
  logic [31:0]   o_rdata;
  logic [1:0]    o_rresp;
  logic          o_rlast;
  logic          o_rvalid;
  logic          i_rready = 1'b0;
  logic          o_timer_irq;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [7:0]  m_div;
  int          m_cnt;
  logic [31:0] m_shadow;
  logic        m_irq;
  logic [33:0] rq[$];
  logic [1:0]  bq[$];

  always #5 clk = ~clk;

  serv_axil_timer #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
    .i_rready(i_rready), .o_timer_irq(o_timer_irq)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic is_mapped(input logic [AW-1:0] a);
    return (a[AW-1:5] == '0) && (a[4:2] <= 3'd4);
  endfunction

  task automatic model_reset();
    m_mtime  = 64'd0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en     = 1'b0;
    m_div    = 8'd0;
    m_cnt    = 0;
    m_shadow = 32'd0;
    m_irq    = 1'b0;
    rq.delete();
    bq.delete();
  endtask

  // Model steps once per cycle at the negedge, predicting the effect of the coming posedge.
  always @(negedge clk) begin : ref_model
    logic [2:0]  idx;
    logic [31:0] val;
    logic [31:0] shadow_next;
    logic [63:0] nt;
    logic        tick;
    logic        irq_next;
    if (!rst) begin
      model_reset();
    end else begin
      chk("timer_irq", 64'(o_timer_irq), 64'(m_irq));
      shadow_next = m_shadow;
      if (i_arvalid && o_arready) begin
        idx = i_araddr[4:2];
        case (idx)
          3'd0: val = m_mtime[31:0];
          3'd1: val = m_shadow;
          3'd2: val = m_cmp[31:0];
          3'd3: val = m_cmp[63:32];
`ifdef SERV_AXIL_TIMER_PRESCALE_EN
          3'd4: val = {16'h0, m_div, 7'h0, m_en};
`else
          3'd4: val = {31'h0, m_en};
`endif
          default: val = 32'h0;
        endcase
        if (is_mapped(i_araddr)) begin
          rq.push_back({2'b00, val});
          if (idx == 3'd0) shadow_next = m_mtime[63:32];
        end else begin
          rq.push_back({2'b10, 32'h0});
        end
      end
`ifdef SERV_AXIL_TIMER_PRESCALE_EN
      tick = m_en && ((m_cnt % (int'(m_div) + 1)) == int'(m_div));
`else
      tick = m_en;
`endif
      irq_next = m_en && (m_mtime >= m_cmp);
      nt = m_mtime + 64'(tick);
      if (m_en) m_cnt++;
      if (i_awvalid && i_wvalid && o_awready && o_wready) begin
        idx = i_awaddr[4:2];
        if (is_mapped(i_awaddr)) begin
          bq.push_back(2'b00);
          case (idx)
            3'd0: nt[31:0]     = merge(nt[31:0], i_wdata, i_wstrb);
            3'd1: nt[63:32]    = merge(nt[63:32], i_wdata, i_wstrb);
            3'd2: m_cmp[31:0]  = merge(m_cmp[31:0], i_wdata, i_wstrb);
            3'd3: m_cmp[63:32] = merge(m_cmp[63:32], i_wdata, i_wstrb);
            default: begin
              if (i_wstrb != 4'b0) begin
                m_cnt = 0;
                if (i_wstrb[0]) m_en = i_wdata[0];
`ifdef SERV_AXIL_TIMER_PRESCALE_EN
                if (i_wstrb[1]) m_div = i_wdata[15:8];
`endif
              end
            end
          endcase
        end else begin
          bq.push_back(2'b10);
        end
      end
      m_mtime  = nt;
      m_irq    = irq_next;
      m_shadow = shadow_next;
    end
  end

  // Monitor: compares every completed response against the queued expectation.
  always @(negedge clk) begin : monitor
    logic [33:0] er;
    logic [1:0]  eb;
    if (rst) begin
      if (o_rvalid && i_rready) begin
        if (rq.size() == 0) fail_now("r_unexpected");
        else begin
          er = rq.pop_front();
          chk("rdata", 64'(o_rdata), 64'(er[31:0]));
          chk("rresp", 64'(o_rresp), 64'(er[33:32]));
          chk("rlast", 64'(o_rlast), 64'd1);
          $display("READ  addr=%h data=%h resp=%0d", i_araddr, o_rdata, o_rresp);
        end
      end
      if (o_bvalid && i_bready) begin
        if (bq.size() == 0) fail_now("b_unexpected");
        else begin
          eb = bq.pop_front();
          chk("bresp", 64'(o_bresp), 64'(eb));
          $display("WRITE addr=%h resp=%0d", i_awaddr, o_bresp);
        end
      end
    end
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bdelay);
    logic ok;
    @(posedge clk); #1;
    i_awaddr = addr; i_wdata = data; i_wstrb = strb;
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_bready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = o_awready && o_wready;
    end
    if (!ok) begin
      fail_now("aw_timeout");
      i_awvalid = 1'b0; i_wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = o_bvalid;
    end
    if (!ok) begin
      fail_now("b_timeout");
      return;
    end
    for (int n = 0; n < bdelay; n++) begin
      @(negedge clk);
      chk("bvalid_hold", 64'(o_bvalid), 64'd1);
    end
    @(posedge clk); #1; i_bready = 1'b1;
    @(posedge clk); #1; i_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int rdelay);
    logic ok;
    @(posedge clk); #1;
    i_araddr = addr; i_arvalid = 1'b1; i_rready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = o_arready;
    end
    if (!ok) begin
      fail_now("ar_timeout");
      i_arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1; i_arvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = o_rvalid;
    end
    if (!ok) begin
      fail_now("r_timeout");
      return;
    end
    for (int n = 0; n < rdelay; n++) begin
      @(negedge clk);
      chk("rvalid_hold", 64'(o_rvalid), 64'd1);
    end
    @(posedge clk); #1; i_rready = 1'b1;
    @(posedge clk); #1; i_rready = 1'b0;
  endtask

  task automatic wait_irq(input logic level, input int budget);
    logic got;
    got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      got = (o_timer_irq == level);
    end
    if (!got) fail_now("irq_wait_timeout");
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a[1:0] = 2'($urandom);
    a[4:2] = 3'($urandom_range(0, 5));
    a[AW-1:5] = ($urandom_range(0, 9) == 0) ? (AW-5)'($urandom) : '0;
    return a;
  endfunction

  function automatic logic [31:0] rand_data(input logic [AW-1:0] a);
    logic [31:0] d;
    d = $urandom;
    if (a[4:2] == 3'd4) begin
      d[15:8] = 8'($urandom_range(0, 3));
      d[0]    = ($urandom_range(0, 3) != 0);
    end else if (a[4:2] == 3'd3 || a[4:2] == 3'd1) begin
      d = ($urandom_range(0, 1) == 0) ? 32'd0 : d;
    end
    return d;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not complete");
  end

  initial begin : stim
    logic [AW-1:0] a;
    logic ok;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_awready", 64'(o_awready), 64'd0);
    chk("rst_bvalid",  64'(o_bvalid),  64'd0);
    chk("rst_arready", 64'(o_arready), 64'd0);
    chk("rst_rvalid",  64'(o_rvalid),  64'd0);
    chk("rst_irq",     64'(o_timer_irq), 64'd0);

    axi_read(12'h008, 0);
    axi_read(12'h00C, 1);
    axi_read(12'h010, 0);

    // Compare at 10 from reset count
    axi_write(12'h008, 32'd10, 4'hF, 0);
    axi_write(12'h00C, 32'd0, 4'hF, 0);
    axi_write(12'h010, 32'd1, 4'hF, 0);
    wait_irq(1'b1, 60);
    axi_read(12'h000, 0);
    axi_read(12'h004, 0);

    // Wrap from all-ones
    axi_write(12'h010, 32'd0, 4'hF, 0);
    axi_write(12'h008, 32'd5, 4'hF, 0);
    axi_write(12'h000, 32'hFFFF_FFFF, 4'hF, 0);
    axi_write(12'h004, 32'hFFFF_FFFF, 4'hF, 1);
    axi_read(12'h004, 0);
    axi_write(12'h010, 32'd1, 4'hF, 0);
    repeat (4) @(posedge clk);
    axi_read(12'h000, 0);
    axi_read(12'h004, 0);
    repeat (6) @(posedge clk);
    axi_read(12'h000, 0);

    // Unmapped write with slow bready, then unmapped reads and full readback
    axi_write(12'h018, 32'h1234_5678, 4'hF, 5);
    axi_write(12'h100, 32'h1234_5678, 4'hF, 0);
    axi_read(12'h018, 0);
    axi_read(12'h11C, 2);
    for (int r = 0; r < 5; r++) axi_read(AW'(4 * r), 0);

    // Concurrent read and byte-0 write
    axi_write(12'h008, 32'h1122_3344, 4'hF, 0);
    fork
      axi_read(12'h000, 0);
      axi_write(12'h008, 32'hAABB_CCDD, 4'b0001, 0);
    join
    axi_read(12'h008, 0);
    axi_write(12'h00A, 32'hFFFF_FFFF, 4'b0000, 1);
    axi_read(12'h008, 0);

    // Divided tick
    axi_write(12'h010, 32'h0000_0301, 4'hF, 0);
    axi_read(12'h010, 0);
    for (int r = 0; r < 4; r++) begin
      repeat (r + 1) @(posedge clk);
      axi_read(12'h000, 0);
    end

    // Randomized traffic
    for (int it = 0; it < 160; it++) begin
      case ($urandom_range(0, 3))
        0: begin a = rand_addr(); axi_write(a, rand_data(a), 4'($urandom), $urandom_range(0, 3)); end
        1: axi_read(rand_addr(), $urandom_range(0, 3));
        2: begin
          a = rand_addr();
          fork
            axi_read(rand_addr(), $urandom_range(0, 3));
            axi_write(a, rand_data(a), 4'($urandom), $urandom_range(0, 3));
          join
        end
        default: repeat ($urandom_range(1, 8)) @(posedge clk);
      endcase
    end

    // Reset while a read response is pending
    @(posedge clk); #1;
    i_araddr = 12'h008; i_arvalid = 1'b1; i_rready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = o_arready; end
    if (!ok) fail_now("ar_timeout_rst");
    @(posedge clk); #1; i_arvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = o_rvalid; end
    if (!ok) fail_now("r_timeout_rst");
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rvalid_async_rst", 64'(o_rvalid), 64'd0);
    chk("rdata_async_rst",  64'(o_rdata),  64'd0);
    chk("irq_async_rst",    64'(o_timer_irq), 64'd0);
    i_rready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("no_resp_after_rst", 64'(o_rvalid), 64'd0);
    end
    i_rready = 1'b0;
    axi_read(12'h008, 0);
    axi_read(12'h010, 0);
    axi_write(12'h000, 32'h0000_00A5, 4'b0001, 0);
    axi_read(12'h000, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("bq_drained", 64'(bq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
